amo_sequencer: RTL and testbench

AMO_SEQUENCER -- requirements
Module: amo_sequencer

---
 rtl/amo_sequencer.sv | 171 +++++++++++++++++
 tb/tb_amo_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amo_sequencer.sv
// rtl/amo_sequencer.sv - RISC-V AMO read-modify-write sequencer (read, ALU, write, respond)
// Optional macro AMO_MINMAX_EN enables the MIN/MAX funct5 decodes.

module amo_sequencer #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [4:0]        req_funct5,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_rs2,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       alu_v1,
   output logic [31:0]       alu_v2,
   output logic [15:0]       alu_op,
   input  logic [63:0]       alu_result
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_CALC,
      S_WRITE,
      S_RESP
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [4:0]        r_funct5;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_rs2;
   logic [31:0]       r_old;
   logic [31:0]       r_new;
   logic              r_err;

   logic [15:0]       w_acc_op;
   logic              w_acc_err;
   logic [15:0]       w_calc_op;
   logic [31:0]       w_unused_alu_hi;

   // A zero code means "not decodable"; every legal op is non-zero.
   function automatic logic [15:0] f_decode(input logic [4:0] i_f);
      logic [15:0] v;
      case (i_f)
         5'b00000: v = 16'd1;
         5'b00001: v = 16'd8192;
         5'b00100: v = 16'd4;
         5'b01000: v = 16'd8;
         5'b01100: v = 16'd16;
`ifdef AMO_MINMAX_EN
         5'b10000: v = 16'd32768;
         5'b10100: v = 16'd16384;
`endif
         default:  v = 16'd0;
      endcase
      return v;
   endfunction

   assign w_acc_op        = f_decode(req_funct5);
   assign w_acc_err       = (w_acc_op == 16'd0) || (req_addr[1:0] != 2'b00);
   assign w_calc_op       = f_decode(r_funct5);
   assign w_unused_alu_hi = alu_result[63:32];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = 32'd0;
      resp_err   = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = 32'd0;
      alu_v1     = 32'd0;
      alu_v2     = 32'd0;
      alu_op     = 16'd0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_next = w_acc_err ? S_RESP : S_READ;
            end
         end
         S_READ: begin
            mem_req  = 1'b1;
            mem_addr = r_addr;
            if (mem_ack) begin
               w_next = S_CALC;
            end
         end
         S_CALC: begin
            alu_v1 = r_old;
            alu_v2 = r_rs2;
            alu_op = w_calc_op;
            w_next = S_WRITE;
         end
         S_WRITE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = r_addr;
            mem_wdata = r_new;
            if (mem_ack) begin
               w_next = S_RESP;
            end
         end
         S_RESP: begin
            resp_valid = 1'b1;
            resp_rdata = r_old;
            resp_err   = r_err;
            if (resp_ready) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // r_old is cleared at acceptance so an error response returns zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_funct5 <= 5'd0;
         r_addr   <= '0;
         r_rs2    <= 32'd0;
         r_old    <= 32'd0;
         r_new    <= 32'd0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_funct5 <= req_funct5;
                  r_addr   <= req_addr;
                  r_rs2    <= req_rs2;
                  r_old    <= 32'd0;
                  r_new    <= 32'd0;
                  r_err    <= w_acc_err;
               end
            end
            S_READ: begin
               if (mem_ack) begin
                  r_old <= mem_rdata;
               end
            end
            S_CALC: begin
               r_new <= alu_result[31:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_amo_sequencer.sv
// tb/tb_amo_sequencer.sv - self-checking bench for amo_sequencer
// Memory and ALU are behavioural models; expected results come from a reference model.

module tb_amo_sequencer;

   localparam int ADDR_W = 32;
`ifdef AMO_MINMAX_EN
   localparam bit MINMAX = 1'b1;
`else
   localparam bit MINMAX = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic [4:0]        req_funct5;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_rs2;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_ack;
   logic [31:0]       mem_rdata;
   logic [31:0]       alu_v1;
   logic [31:0]       alu_v2;
   logic [15:0]       alu_op;
   logic [63:0]       alu_result;

   int n_checks = 0;
   int n_fail   = 0;

   amo_sequencer #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_funct5(req_funct5),
      .req_addr(req_addr), .req_rs2(req_rs2),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_op(alu_op), .alu_result(alu_result)
   );

   always #5 clk = ~clk;

   // ALU model; the upper half carries junk that must never reach memory.
   always_comb begin
      alu_result = {32'hDEADBEEF, 32'h5A5A5A5A};
      case (alu_op)
         16'd1:     alu_result[31:0] = alu_v1 + alu_v2;
         16'd8192:  alu_result[31:0] = alu_v2;
         16'd4:     alu_result[31:0] = alu_v1 ^ alu_v2;
         16'd8:     alu_result[31:0] = alu_v1 | alu_v2;
         16'd16:    alu_result[31:0] = alu_v1 & alu_v2;
         16'd32768: alu_result[31:0] = ($signed(alu_v1) < $signed(alu_v2)) ? alu_v1 : alu_v2;
         16'd16384: alu_result[31:0] = ($signed(alu_v1) > $signed(alu_v2)) ? alu_v1 : alu_v2;
         default:   alu_result[31:0] = 32'h5A5A5A5A;
      endcase
   end

   logic [31:0]       mem_model [0:255];
   int                rwait_cfg = 0;
   int                wwait_cfg = 0;
   bit                no_wack   = 1'b0;
   bit                stray_ack = 1'b0;
   int                wcnt      = 0;
   int                wr_count  = 0;
   logic [31:0]       last_wdata = 32'd0;
   logic [ADDR_W-1:0] last_waddr = '0;

   always @(negedge clk) begin
      if (mem_req) begin
         if (!(no_wack && mem_we) && wcnt == (mem_we ? wwait_cfg : rwait_cfg)) begin
            mem_ack = 1'b1;
            wcnt    = 0;
            if (mem_we) begin
               mem_model[mem_addr[9:2]] = mem_wdata;
               wr_count   = wr_count + 1;
               last_wdata = mem_wdata;
               last_waddr = mem_addr;
               mem_rdata  = $urandom;
            end else begin
               mem_rdata = mem_model[mem_addr[9:2]];
            end
         end else begin
            mem_ack   = 1'b0;
            wcnt      = wcnt + 1;
            mem_rdata = $urandom;
         end
      end else begin
         mem_ack   = stray_ack;
         wcnt      = 0;
         mem_rdata = $urandom;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: what an AMO should do, from funct5 semantics and alignment.
   task automatic ref_amo(input logic [4:0] f5, input logic [31:0] addr, input logic [31:0] old,
                          input logic [31:0] rs2, output logic err, output logic [31:0] wd,
                          output logic [15:0] op);
      err = 1'b0;
      wd  = 32'd0;
      op  = 16'd0;
      case (f5)
         5'd0:  begin wd = old + rs2; op = 16'd1;    end
         5'd1:  begin wd = rs2;       op = 16'd8192; end
         5'd4:  begin wd = old ^ rs2; op = 16'd4;    end
         5'd8:  begin wd = old | rs2; op = 16'd8;    end
         5'd12: begin wd = old & rs2; op = 16'd16;   end
         5'd16: begin
            if (MINMAX) begin
               wd = ($signed(old) < $signed(rs2)) ? old : rs2;
               op = 16'd32768;
            end else err = 1'b1;
         end
         5'd20: begin
            if (MINMAX) begin
               wd = ($signed(old) > $signed(rs2)) ? old : rs2;
               op = 16'd16384;
            end else err = 1'b1;
         end
         default: err = 1'b1;
      endcase
      if (addr[1:0] != 2'b00) err = 1'b1;
      if (err) begin
         wd = 32'd0;
         op = 16'd0;
      end
   endtask

   task automatic do_amo(input string name, input logic [4:0] f5, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [31:0] old, input int rw, input int ww,
                         input int hold, input logic exp_err, input logic [31:0] exp_rdata,
                         input logic [31:0] exp_wdata, input logic [15:0] exp_op);
      int          k;
      int          first_resp;
      int          rd_cyc;
      int          wr_cyc;
      int          alu_cyc;
      int          wr0;
      int          exp_lat;
      logic [15:0] seen_op;
      logic [31:0] v1s;
      logic [31:0] v2s;
      logic [31:0] rsnap;
      bit          addr_ok;
      bit          alu_ok;
      bit          ready_ok;
      bit          hold_ok;
      mem_model[addr[9:2]] = old;
      rwait_cfg = rw;
      wwait_cfg = ww;
      wr0       = wr_count;
      k = 0; first_resp = -1; rd_cyc = 0; wr_cyc = 0; alu_cyc = 0;
      seen_op = 16'd0; v1s = 32'd0; v2s = 32'd0;
      addr_ok = 1'b1; alu_ok = 1'b1; ready_ok = 1'b1; hold_ok = 1'b1;
      @(negedge clk);
      check({name, "/ready_idle"}, 64'(req_ready), 64'd1);
      req_funct5 = f5;
      req_addr   = addr;
      req_rs2    = rs2;
      req_valid  = 1'b1;
      @(posedge clk);
      while (first_resp < 0 && k < 60) begin
         @(negedge clk);
         k = k + 1;
         req_valid  = 1'b0;
         req_funct5 = 5'($urandom);
         req_addr   = $urandom;
         req_rs2    = $urandom;
         if (mem_req) begin
            if (mem_we) wr_cyc = wr_cyc + 1;
            else        rd_cyc = rd_cyc + 1;
            if (mem_addr !== addr) addr_ok = 1'b0;
         end
         if (alu_op != 16'd0) begin
            alu_cyc = alu_cyc + 1;
            seen_op = alu_op;
            v1s     = alu_v1;
            v2s     = alu_v2;
         end else if (alu_v1 !== 32'd0 || alu_v2 !== 32'd0) begin
            alu_ok = 1'b0;
         end
         if (req_ready !== 1'b0) ready_ok = 1'b0;
         if (resp_valid) first_resp = k;
      end
      check({name, "/resp_seen"}, 64'(first_resp >= 0), 64'd1);
      if (first_resp < 0) return;
      exp_lat = exp_err ? 1 : 4 + rw + ww;
      check({name, "/latency"}, 64'(first_resp), 64'(exp_lat));
      check({name, "/resp_err"}, 64'(resp_err), 64'(exp_err));
      check({name, "/resp_rdata"}, 64'(resp_rdata), 64'(exp_rdata));
      check({name, "/rd_cycles"}, 64'(rd_cyc), exp_err ? 64'd0 : 64'(rw + 1));
      check({name, "/wr_cycles"}, 64'(wr_cyc), exp_err ? 64'd0 : 64'(ww + 1));
      check({name, "/mem_addr"}, 64'(addr_ok), 64'd1);
      check({name, "/alu_cycles"}, 64'(alu_cyc), exp_err ? 64'd0 : 64'd1);
      check({name, "/alu_op"}, 64'(seen_op), 64'(exp_op));
      check({name, "/alu_idle_zero"}, 64'(alu_ok), 64'd1);
      check({name, "/busy_not_ready"}, 64'(ready_ok), 64'd1);
      check({name, "/writes"}, 64'(wr_count - wr0), exp_err ? 64'd0 : 64'd1);
      if (!exp_err) begin
         check({name, "/alu_v1"}, 64'(v1s), 64'(old));
         check({name, "/alu_v2"}, 64'(v2s), 64'(rs2));
         check({name, "/wdata"}, 64'(last_wdata), 64'(exp_wdata));
         check({name, "/waddr"}, 64'(last_waddr), 64'(addr));
      end
      rsnap = resp_rdata;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         if (resp_valid !== 1'b1 || resp_rdata !== rsnap || req_ready !== 1'b0 ||
             resp_err !== exp_err) hold_ok = 1'b0;
      end
      if (hold > 0) check({name, "/resp_hold"}, 64'(hold_ok), 64'd1);
      // A request offered on the handshake edge must not be taken.
      resp_ready = 1'b1;
      req_valid  = 1'b1;
      req_funct5 = 5'd0;
      req_addr   = 32'h200;
      req_rs2    = 32'd1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      check({name, "/no_accept_on_handshake"}, 64'({resp_valid, req_ready, mem_req}), 64'b010);
      req_valid = 1'b0;
   endtask

   typedef struct {
      logic [4:0]  f5;
      logic [31:0] addr;
      logic [31:0] rs2;
      logic [31:0] old;
      int          rw;
      int          ww;
      int          hold;
      logic        err;
      logic [31:0] rdata;
      logic [31:0] wdata;
      logic [15:0] op;
   } vec_t;

   vec_t        tbl [9];
   logic [4:0]  codes [10];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        e_err;
      logic [31:0] e_wd;
      logic [15:0] e_op;
      logic [4:0]  f5;
      logic [31:0] addr;
      logic [31:0] old;
      logic [31:0] rs2;
      int          wr0;
      int          guard;

      tbl[0] = '{5'b00000, 32'h100, 32'd3,        32'd5,        0, 0, 0, 1'b0, 32'd5,        32'd8,        16'd1};
      tbl[1] = '{5'b00001, 32'h104, 32'h1234,     32'hAAAA,     2, 2, 0, 1'b0, 32'hAAAA,     32'h1234,     16'd8192};
      tbl[2] = '{5'b11111, 32'h108, 32'd7,        32'h77,       0, 0, 1, 1'b1, 32'd0,        32'd0,        16'd0};
      tbl[3] = '{5'b00000, 32'h102, 32'd7,        32'h77,       0, 0, 0, 1'b1, 32'd0,        32'd0,        16'd0};
`ifdef AMO_MINMAX_EN
      tbl[4] = '{5'b10100, 32'h10C, 32'd9,        32'd7,        0, 0, 0, 1'b0, 32'd7,        32'd9,        16'd16384};
      tbl[8] = '{5'b10000, 32'h11C, 32'd1,        32'hFFFFFFFF, 1, 0, 0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'd32768};
`else
      tbl[4] = '{5'b10100, 32'h10C, 32'd9,        32'd7,        0, 0, 0, 1'b1, 32'd0,        32'd0,        16'd0};
      tbl[8] = '{5'b10000, 32'h11C, 32'd1,        32'hFFFFFFFF, 1, 0, 0, 1'b1, 32'd0,        32'd0,        16'd0};
`endif
      tbl[5] = '{5'b00100, 32'h110, 32'hFF,       32'hF0,       0, 0, 3, 1'b0, 32'hF0,       32'h0F,       16'd4};
      tbl[6] = '{5'b01000, 32'h114, 32'h0F0F,     32'hF0F0,     1, 2, 0, 1'b0, 32'hF0F0,     32'hFFFF,     16'd8};
      tbl[7] = '{5'b01100, 32'h118, 32'h0FF0,     32'hFF00,     0, 1, 2, 1'b0, 32'hFF00,     32'h0F00,     16'd16};
      codes  = '{5'd0, 5'd1, 5'd4, 5'd8, 5'd12, 5'd16, 5'd20, 5'd31, 5'd2, 5'd3};

      reset      = 1'b1;
      req_valid  = 1'b0;
      req_funct5 = 5'd0;
      req_addr   = '0;
      req_rs2    = 32'd0;
      resp_ready = 1'b0;
      for (int i = 0; i < 256; i++) mem_model[i] = 32'd0;

      @(negedge clk);
      check("reset/req_ready", 64'(req_ready), 64'd1);
      check("reset/resp", 64'({resp_valid, resp_err, resp_rdata}), 64'd0);
      check("reset/mem", 64'({mem_req, mem_we, mem_addr, mem_wdata}), 64'd0);
      check("reset/alu", 64'({alu_op, alu_v1}), 64'd0);
      check("reset/alu_v2", 64'(alu_v2), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 9; i++) begin
         do_amo($sformatf("vec%0d", i), tbl[i].f5, tbl[i].addr, tbl[i].rs2, tbl[i].old,
                tbl[i].rw, tbl[i].ww, tbl[i].hold, tbl[i].err, tbl[i].rdata, tbl[i].wdata,
                tbl[i].op);
      end

      // Acks while no access is outstanding must be ignored.
      stray_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stray_ack/idle", 64'({mem_req, req_ready}), 64'b01);
      end
      do_amo("stray_ack/add", 5'd0, 32'h120, 32'd10, 32'd20, 0, 1, 1, 1'b0, 32'd20, 32'd30, 16'd1);
      stray_ack = 1'b0;

      // Reset in the middle of a stalled write.
      no_wack = 1'b1;
      mem_model[32'h130 >> 2] = 32'h55;
      wr0 = wr_count;
      @(negedge clk);
      req_funct5 = 5'd0;
      req_addr   = 32'h130;
      req_rs2    = 32'd1;
      req_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      guard = 0;
      while (!(mem_req && mem_we) && guard < 20) begin
         @(negedge clk);
         guard = guard + 1;
      end
      check("rst_mid_write/reached_write", 64'(mem_req && mem_we), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      check("rst_mid_write/mem_cleared", 64'({mem_req, mem_we, mem_addr, mem_wdata}), 64'd0);
      check("rst_mid_write/ready", 64'({req_ready, resp_valid}), 64'b10);
      @(negedge clk);
      reset   = 1'b0;
      no_wack = 1'b0;
      check("rst_mid_write/no_write", 64'(wr_count - wr0), 64'd0);
      check("rst_mid_write/mem_kept", 64'(mem_model[32'h130 >> 2]), 64'h55);
      do_amo("after_reset/xor", 5'b00100, 32'h134, 32'hFF, 32'hF0, 0, 0, 0, 1'b0, 32'hF0,
             32'h0F, 16'd4);

      for (int i = 0; i < 40; i++) begin
         f5   = codes[$urandom_range(0, 9)];
         addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
         old  = $urandom;
         rs2  = $urandom;
         ref_amo(f5, addr, old, rs2, e_err, e_wd, e_op);
         do_amo($sformatf("rand%0d", i), f5, addr, rs2, old, $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom_range(0, 2), e_err, e_err ? 32'd0 : old, e_wd,
                e_op);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
